// File: rtl/arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_rotate_16.sv
// Combinational 16-bit rotate-right: dout[k] = din[(k + amt) mod 16].
module rr_rotate_16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    input  req_id_t          amt,
    output logic [N_REQ-1:0] dout
);

    // A shift by the full width yields zero, so amt == 0 needs no special case.
    assign dout = (din >> amt) | (din << (6'(N_REQ) - 6'(amt)));

endmodule

// File: rtl/arbiter_16_rr.sv
// Round-robin arbiter with active-low requests and one-cold grants, held until release.
// Define ARB_TIMEOUT_EN to build the hold counter that forces release after MAX_HOLD cycles.
module arbiter_16_rr
    import arb_pkg::*;
#(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 255,
    parameter int PTR_INIT = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ_N,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT_N,
    output req_id_t          GNT_ID,
    output logic             GNT_VLD,
    output logic             TIMEOUT
);

    localparam req_id_t PTR_RST = req_id_t'(PTR_INIT);

    if (MAX_HOLD < 1 || MAX_HOLD >= (2 ** HOLD_W) || PTR_INIT < 0 || PTR_INIT >= N_REQ) begin : g_bad_cfg
        $error("arbiter_16_rr: MAX_HOLD or PTR_INIT out of range");
    end

    arb_state_t       state;
    req_id_t          ptr;
    req_id_t          offset;
    req_id_t          winner;
    logic [N_REQ-1:0] rot;
    logic             found;
    logic             any;
    logic             owner_rel;
    logic             force_rel;

    rr_rotate_16 u_rot (
        .din  (REQ_N),
        .amt  (ptr),
        .dout (rot)
    );

    // Lowest asserted (zero) position in the rotated vector is the distance from ptr.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && !rot[k]) begin
                found  = 1'b1;
                offset = req_id_t'(k);
            end
        end
    end

    assign any       = ~&REQ_N;
    assign winner    = ptr + offset;
    assign owner_rel = DONE | REQ_N[GNT_ID];

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    assign force_rel = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // TIMEOUT only flags a release that the owner did not ask for itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt <= '0;
            TIMEOUT  <= 1'b0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
            TIMEOUT  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            TIMEOUT  <= force_rel & ~owner_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign TIMEOUT   = 1'b0;
`endif

    // Every release passes through IDLE, which gives the one-cycle bubble between grants.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= PTR_RST;
            GNT_N   <= '1;
            GNT_ID  <= '0;
            GNT_VLD <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= GRANT;
                        GNT_ID  <= winner;
                        GNT_N   <= ~(N_REQ'(1) << winner);
                        GNT_VLD <= 1'b1;
                    end
                end
                GRANT: begin
                    if (owner_rel || force_rel) begin
                        state   <= IDLE;
                        ptr     <= GNT_ID + req_id_t'(1);
                        GNT_N   <= '1;
                        GNT_VLD <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
